// File: rtl/ads868x_spi_responder.sv
// ADS868x stand-in for loopback/bring-up: decodes 16..32-bit SPI frames (CPOL=0, CPHA=1)
// and answers with register bytes or conversion data taken from a 4-entry sample table.
module ads868x_spi_responder #(
    parameter int C_NUM_REGS    = 64,
    parameter int C_SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        SCLK,
    input  logic        CS_N,
    input  logic        SDI,
    output logic        SDO,
    input  logic        RST_PD_N,
    input  logic [15:0] smp_tdata,
    input  logic [1:0]  smp_tchan,
    input  logic        smp_tvalid,
    output logic [15:0] stat_last_cmd,
    output logic [15:0] stat_frame_cnt,
    output logic        stat_frame_err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DECODE = 2'd2} state_t;

    localparam int LAST = C_SYNC_STAGES - 1;
    // Pin order {RST_PD_N, SDI, CS_N, SCLK}. CS_N resets low so that releasing reset while
    // the master still holds CS_N low is not mistaken for the start of a new frame.
    localparam logic [3:0] SYNC_INIT = 4'b1000;

    logic [3:0]  sync_q [C_SYNC_STAGES];
    logic [3:0]  sync_d [C_SYNC_STAGES];
    logic [1:0]  prev_q, prev_d;
    logic        sclk_s, cs_s, sdi_s, pd_n_s;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] rx_sr_q, rx_sr_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic        sdo_q, sdo_d;
    logic [7:0]  regs_q [C_NUM_REGS];
    logic [7:0]  regs_d [C_NUM_REGS];
    logic [15:0] smp_tab_q [4];
    logic [15:0] smp_tab_d [4];
    logic [15:0] conv_q, conv_d;
    logic [1:0]  cur_ch_q, cur_ch_d;
    logic [15:0] last_cmd_q, last_cmd_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] rd_cmd, dec_cmd;

    assign sync_d[0] = {RST_PD_N, SDI, CS_N, SCLK};
    for (genvar gi = 1; gi < C_SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi - 1];
    end

    assign sclk_s    = sync_q[LAST][0];
    assign cs_s      = sync_q[LAST][1];
    assign sdi_s     = sync_q[LAST][2];
    assign pd_n_s    = sync_q[LAST][3];
    assign prev_d    = {cs_s, sclk_s};
    assign sclk_rise = sclk_s & ~prev_q[0];
    assign sclk_fall = ~sclk_s & prev_q[0];
    assign cs_rise   = cs_s & ~prev_q[1];
    assign cs_fall   = ~cs_s & prev_q[1];

    // The 16-bit command is the first 16 bits in; once the frame is over it sits
    // bit_cnt-16 places above the bottom of the receive shifter.
    assign rd_cmd  = {rx_sr_q[14:0], sdi_s};
    assign dec_cmd = 16'(rx_sr_q >> (bit_cnt_q - 6'd16));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        sdo_d       = sdo_q;
        regs_d      = regs_q;
        smp_tab_d   = smp_tab_q;
        conv_d      = conv_q;
        cur_ch_d    = cur_ch_q;
        last_cmd_d  = last_cmd_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = 1'b0;

        if (smp_tvalid) begin
            smp_tab_d[smp_tchan] = smp_tdata;
        end

        if (!pd_n_s) begin
            state_d  = S_IDLE;
            sdo_d    = 1'b0;
            cur_ch_d = 2'd0;
            conv_d   = 16'h0000;
            for (int i = 0; i < C_NUM_REGS; i++) regs_d[i] = 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sdo_d = 1'b0;
                    if (cs_fall) begin
                        state_d   = S_SHIFT;
                        bit_cnt_d = 6'd0;
                        rx_sr_d   = 32'h0;
                        tx_sr_d   = {16'h0000, conv_q};
                    end
                end
                S_SHIFT: begin
                    if (cs_rise) begin
                        state_d = S_DECODE;
                        sdo_d   = 1'b0;
                    end else if (sclk_fall) begin
                        rx_sr_d = {rx_sr_q[30:0], sdi_s};
                        if (bit_cnt_q != 6'd33) bit_cnt_d = bit_cnt_q + 6'd1;
                        // A register read replaces the outgoing data right after the command.
                        if (bit_cnt_q == 6'd15 && !rd_cmd[15] && !rd_cmd[8] && rd_cmd != 16'h0) begin
                            if (int'(rd_cmd[14:9]) < C_NUM_REGS) tx_sr_d = {regs_q[rd_cmd[14:9]], 24'h0};
                            else tx_sr_d = 32'h0;
                        end
                    end else if (sclk_rise) begin
                        sdo_d   = tx_sr_q[31];
                        tx_sr_d = {tx_sr_q[30:0], 1'b0};
                    end
                end
                S_DECODE: begin
                    state_d = S_IDLE;
                    sdo_d   = 1'b0;
                    if (bit_cnt_q < 6'd16 || bit_cnt_q > 6'd32) begin
                        frame_err_d = 1'b1;
                    end else begin
                        last_cmd_d  = dec_cmd;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        conv_d      = smp_tab_q[cur_ch_q];
                        case (dec_cmd)
                            16'hC000: cur_ch_d = 2'd0;
                            16'hC400: cur_ch_d = 2'd1;
                            16'hC800: cur_ch_d = 2'd2;
                            16'hCC00: cur_ch_d = 2'd3;
                            default:  cur_ch_d = cur_ch_q;
                        endcase
                        if (!dec_cmd[15] && dec_cmd[8] && int'(dec_cmd[15:9]) < C_NUM_REGS) begin
                            regs_d[dec_cmd[14:9]] = dec_cmd[7:0];
                        end
                        if (dec_cmd == 16'h8500) begin
                            cur_ch_d = 2'd0;
                            conv_d   = 16'h0000;
                            for (int i = 0; i < C_NUM_REGS; i++) regs_d[i] = 8'h00;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < C_SYNC_STAGES; i++) sync_q[i] <= SYNC_INIT;
            prev_q      <= SYNC_INIT[1:0];
            state_q     <= S_IDLE;
            bit_cnt_q   <= 6'd0;
            rx_sr_q     <= 32'h0;
            tx_sr_q     <= 32'h0;
            sdo_q       <= 1'b0;
            for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= 8'h00;
            for (int i = 0; i < 4; i++) smp_tab_q[i] <= 16'h0000;
            conv_q      <= 16'h0000;
            cur_ch_q    <= 2'd0;
            last_cmd_q  <= 16'h0000;
            frame_cnt_q <= 16'h0000;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            sdo_q       <= sdo_d;
            regs_q      <= regs_d;
            smp_tab_q   <= smp_tab_d;
            conv_q      <= conv_d;
            cur_ch_q    <= cur_ch_d;
            last_cmd_q  <= last_cmd_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign SDO            = sdo_q;
    assign stat_last_cmd  = last_cmd_q;
    assign stat_frame_cnt = frame_cnt_q;
    assign stat_frame_err = frame_err_q;
endmodule
